// File: rtl/hedios_cmd_decoder.sv
// Byte-stream command decoder in front of the HEDIOS register bank.
// Parses write/read frames, strobes the bank write port and streams read data back.
module hedios_cmd_decoder #(
    parameter int DEPTH  = 8,
    parameter int N_REGS = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DEPTH-1:0]  wr_data,
    output logic              wr_we,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DEPTH-1:0]  rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err
);

    localparam int         NBYTES   = (DEPTH + 7) / 8;
    localparam int         SR_W     = NBYTES * 8;
    localparam logic [2:0] LAST_CNT = 3'(NBYTES - 1);
    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] OP_RD    = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_WRITE   = 3'd3,
        S_RLATCH  = 3'd4,
        S_SEND    = 3'd5,
        S_DISCARD = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SR_W-1:0]   data_sr_q, data_sr_d;
    logic [SR_W-1:0]   tx_sr_q, tx_sr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DEPTH-1:0]  wr_data_q, wr_data_d;
    logic              wr_we_q, wr_we_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              err_q, err_d;
    logic              rx_ready_q, rx_ready_d;

    logic              rx_fire_s;
    logic              tx_fire_s;
    logic              addr_bad_s;
    logic [SR_W-1:0]   data_next_s;
    logic [SR_W-1:0]   rd_pad_s;
    logic [SR_W-1:0]   tx_shift_s;

    // Next-state and registered-output computation for the frame parser.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        data_sr_d  = data_sr_q;
        tx_sr_d    = tx_sr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_we_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;

        rx_fire_s   = rx_valid & rx_ready_q;
        tx_fire_s   = tx_valid_q & tx_ready;
        addr_bad_s  = ({24'd0, rx_data} >= 32'(N_REGS));
        data_next_s = (data_sr_q << 4'd8) | SR_W'(rx_data);
        tx_shift_s  = tx_sr_q << 4'd8;
        // Zero-pad the register value so the first tx byte carries 0s above DEPTH.
        rd_pad_s              = '0;
        rd_pad_s[DEPTH-1:0]   = rd_data;

        case (state_q)
            S_IDLE: begin
                if (rx_fire_s) begin
                    if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
                        is_wr_d = (rx_data == OP_WR);
                        state_d = S_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (rx_fire_s) begin
                    addr_d = ADDR_W'(rx_data);
                    cnt_d  = 3'd0;
                    if (addr_bad_s) begin
                        err_d   = 1'b1;
                        state_d = is_wr_q ? S_DISCARD : S_IDLE;
                    end else if (is_wr_q) begin
                        state_d = S_DATA;
                    end else begin
                        rd_addr_d = ADDR_W'(rx_data);
                        state_d   = S_RLATCH;
                    end
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (rx_fire_s) begin
                    data_sr_d = data_next_s;
                    if (cnt_q == LAST_CNT) begin
                        wr_data_d = data_next_s[DEPTH-1:0];
                        wr_addr_d = addr_q;
                        wr_we_d   = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_RLATCH: begin
                tx_sr_d    = rd_pad_s;
                tx_data_d  = rd_pad_s[SR_W-1 -: 8];
                tx_valid_d = 1'b1;
                cnt_d      = 3'd0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (tx_fire_s) begin
                    if (cnt_q == LAST_CNT) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_sr_d   = tx_shift_s;
                        tx_data_d = tx_shift_s[SR_W-1 -: 8];
                        cnt_d     = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DISCARD: begin
                if (rx_fire_s) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // Input is only accepted where a byte can be absorbed without loss.
        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                     (state_d == S_DATA) || (state_d == S_DISCARD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            data_sr_q  <= '0;
            tx_sr_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            data_sr_q  <= data_sr_d;
            tx_sr_q    <= tx_sr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_we_q    <= wr_we_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_we    = wr_we_q;
    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule
